icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache answering the fetch unit's one-outstanding-PC handshake (`pc_cache`/`pc_flag` in, `ins_ori`/`ins_ori_flag` out). On a miss it runs a word-level refill through the memory controller. A redirect (`jp_ok`) discards any pending answer. It sits between the fetch unit and the memory controller/arbiter.

## Interface
Parameters:
- `IDX_W`, 6: index bits; the cache has 2^IDX_W one-word lines.
- `TAG_W`, 30-IDX_W: tag width, pc[31:2+IDX_W].

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  global enable; low freezes all state.
- `pc_cache`  in  32  fetch address from the fetch unit; pc[1:0] ignored.
- `pc_flag`  in  1  fetch request valid this cycle.
- `jp_ok`  in  1  redirect from ROB; squash the pending answer.
- `ins_ori`  out  32  instruction word; valid only with `ins_ori_flag`.
- `ins_ori_flag`  out  1  one-cycle pulse: `ins_ori` answers the last accepted `pc_flag`.
- `mem_req`  out  1  refill request; held until `mem_done`.
- `mem_addr`  out  32  refill word address, {pc[31:2],2'b00}; stable while `mem_req`=1.
- `mem_data`  in  32  refill word, little-endian assembled by the controller.
- `mem_done`  in  1  one-cycle pulse: `mem_data` valid, request complete.

## Operation
- Storage: `valid[2^IDX_W]` in flops, cleared by reset. `tag` and `data` arrays are not reset.
- States: IDLE, MISS, RESP.
- IDLE, `pc_flag`=1, `jp_ok`=0:
  - Hit (valid[idx] and tag match): register `data[idx]` into `ins_ori`, go to RESP.
  - Miss: latch pc into `mem_addr`, assert `mem_req`, go to MISS.
- IDLE, `pc_flag`=1 together with `jp_ok`=1: request dropped, stay IDLE, no response.
- MISS:
  - `mem_req` is held high.
  - On `mem_done`: write `data`/`tag`, set `valid[idx]`, drop `mem_req`.
  - If not squashed: load `ins_ori` from `mem_data` and go to RESP. If squashed: go to IDLE.
- Squash flag: set by `jp_ok` while in MISS, or by `jp_ok` coinciding with `mem_done`. Cleared on leaving MISS. A squashed refill still fills the line; memory transactions are never cancelled.
- RESP:
  - `ins_ori_flag`=1 for exactly one cycle, then IDLE.
  - `jp_ok` in RESP does not suppress the pulse; the fetch unit ignores it.
- `pc_flag` outside IDLE is ignored.
- `rdy`=0: state, outputs and arrays hold. `mem_done` is not expected while `rdy`=0.

## Timing
- Reset values: `ins_ori_flag`=0, `ins_ori`=0, `mem_req`=0, `mem_addr`=0, state IDLE, all `valid`=0, squash=0.
- Reset mid-refill aborts immediately; a late `mem_done` in IDLE is ignored.
- Hit latency: `pc_flag` sampled at edge N, `ins_ori_flag` high during cycle N+1.
- Miss latency: `mem_req` rises at edge N+1. If `mem_done` arrives during cycle M, `ins_ori_flag` is high in cycle M+1.
- Back-to-back hits: the fetch unit drops `pc_flag` during the response cycle, so at most one answer per 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Index and tag: idx = pc[2+IDX_W-1:2], tag = pc[31:2+IDX_W]. No wrap-around special case; address 0xFFFFFFFC is legal.

## Structure
- Shared package holds:
  - state encodings IC_IDLE/IC_MISS/IC_RESP (2 bits);
  - `ADDR_W`=32 and `INST_W`=32;
  - the default `IDX_W`.
- One sub-module, `icache_line_store`: tag/data arrays with a synchronous write port and an asynchronous read port indexed by idx. The valid bits stay in the parent so they receive the async reset.

## Test plan
- Cold miss:
  - Stimulus: `pc_flag` with pc=0x00000000; `mem_done` 5 cycles later with `mem_data`=0x00000093.
  - Required: `mem_req`=1 with `mem_addr`=0; one `ins_ori_flag` pulse with `ins_ori`=0x00000093 the cycle after `mem_done`.
- Hit:
  - Stimulus: re-request pc=0x00000000.
  - Required: no `mem_req`; `ins_ori_flag` the next cycle with 0x00000093.
- Conflict:
  - Stimulus: fill pc=0x4 (IDX_W=6), then request pc=0x104 (same index, different tag), then pc=0x4 again.
  - Required: a refill for each of the three requests.
- Squash during miss:
  - Stimulus: request pc=0x8; pulse `jp_ok` 2 cycles later; `mem_done` later with 0x12345678.
  - Required: no `ins_ori_flag`; a subsequent pc=0x8 request hits with 0x12345678.
- Coincident requests:
  - Stimulus: `pc_flag` and `jp_ok` in the same cycle in IDLE.
  - Required: no `mem_req`, no response.
- Reset and stall:
  - Stimulus: assert `rst_n`=0 mid-MISS; separately, hold `rdy`=0 for 3 cycles in RESP.
  - Required: reset clears all outputs asynchronously and the next access to the previously filled line misses. With `rdy`=0 the `ins_ori_flag` pulse is stretched across the stall and ends one cycle after `rdy` returns.

Source files
------------

// File: rtl/icache_pkg.sv
// icache shared definitions.
// State encodings, bus widths and default geometry.
package icache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_MISS = 2'd1,
    IC_RESP = 2'd2
  } ic_state_e;

  localparam int ADDR_W    = 32;
  localparam int INST_W    = 32;
  localparam int IDX_W_DEF = 6;

endpackage

// File: rtl/icache_line_store.sv
// icache tag/data arrays.
// Sync write port, async read port; not reset.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [INST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [TAG_W-1:0]  rtag,
  output logic [INST_W-1:0] rdata
);

  localparam int NL = 1 << IDX_W;

  logic [TAG_W-1:0]  tag_q  [NL];
  logic [INST_W-1:0] data_q [NL];

  // refill write: one line per completed memory word
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rtag  = tag_q[ridx];
  assign rdata = data_q[ridx];

endmodule

// File: rtl/icache.sv
// icache top: direct-mapped read-only cache.
// One outstanding fetch, word refill, squashable answer.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_cache,
  input  logic              pc_flag,
  input  logic              jp_ok,
  output logic [INST_W-1:0] ins_ori,
  output logic              ins_ori_flag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_data,
  input  logic              mem_done
);

  localparam int NL = 1 << IDX_W;

  ic_state_e         state_q, state_d;
  logic              squash_q, squash_d;
  logic [NL-1:0]     valid_q, valid_d;
  logic [INST_W-1:0] ins_ori_q, ins_ori_d;
  logic              flag_q, flag_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [IDX_W-1:0]  pc_idx, miss_idx;
  logic [TAG_W-1:0]  pc_tag, miss_tag, rtag;
  logic [INST_W-1:0] rdata;
  logic              hit, fill, killed;
  logic              unused_ok;

  assign pc_idx   = pc_cache[2 +: IDX_W];
  assign pc_tag   = pc_cache[ADDR_W-1 -: TAG_W];
  assign miss_idx = mem_addr_q[2 +: IDX_W];
  assign miss_tag = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign hit      = valid_q[pc_idx] && (rtag == pc_tag);
  assign fill     = rdy && (state_q == IC_MISS) && mem_done;
  assign killed   = squash_q || jp_ok;
  assign unused_ok = &{1'b0, pc_cache[1:0]};

  icache_line_store #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_store (
    .clk  (clk),
    .we   (fill),
    .widx (miss_idx),
    .wtag (miss_tag),
    .wdata(mem_data),
    .ridx (pc_idx),
    .rtag (rtag),
    .rdata(rdata)
  );

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IC_IDLE;
      squash_q   <= 1'b0;
      valid_q    <= '0;
      ins_ori_q  <= '0;
      flag_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      valid_q    <= valid_d;
      ins_ori_q  <= ins_ori_d;
      flag_q     <= flag_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // next state; rdy low freezes everything
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      unique case (state_q)
        IC_IDLE: begin
          if (pc_flag && !jp_ok)
            state_d = hit ? IC_RESP : IC_MISS;
        end
        IC_MISS: begin
          if (mem_done)
            state_d = killed ? IC_IDLE : IC_RESP;
        end
        IC_RESP: state_d = IC_IDLE;
        default: state_d = IC_IDLE;
      endcase
    end
  end

  // outputs, squash tracking and valid bits
  always_comb begin
    ins_ori_d  = ins_ori_q;
    flag_d     = flag_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    squash_d   = squash_q;
    valid_d    = valid_q;
    if (rdy) begin
      flag_d = 1'b0;
      unique case (state_q)
        IC_IDLE: begin
          if (pc_flag && !jp_ok) begin
            if (hit) begin
              ins_ori_d = rdata;
              flag_d    = 1'b1;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = {pc_cache[ADDR_W-1:2], 2'b00};
            end
          end
        end
        IC_MISS: begin
          squash_d = killed;
          if (mem_done) begin
            valid_d[miss_idx] = 1'b1;
            mem_req_d         = 1'b0;
            squash_d          = 1'b0;
            if (!killed) begin
              ins_ori_d = mem_data;
              flag_d    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ins_ori      = ins_ori_q;
  assign ins_ori_flag = flag_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// icache testbench.
// Directed scenarios plus random traffic vs. a line-table model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] pc_cache = '0;
  logic        pc_flag = 1'b0;
  logic        jp_ok = 1'b0;
  logic [31:0] ins_ori;
  logic        ins_ori_flag;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // model: which word address each line holds, and its data
  bit          m_v    [64];
  logic [31:0] m_addr [64];
  logic [31:0] m_data [64];

  icache dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .pc_cache(pc_cache), .pc_flag(pc_flag), .jp_ok(jp_ok),
    .ins_ori(ins_ori), .ins_ori_flag(ins_ori_flag),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int line_of(logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    int l = line_of(a);
    return m_v[l] && (m_addr[l] == {a[31:2], 2'b00});
  endfunction

  function automatic void m_fill(logic [31:0] a, logic [31:0] d);
    int l = line_of(a);
    m_v[l] = 1'b1;
    m_addr[l] = {a[31:2], 2'b00};
    m_data[l] = d;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
  endfunction

  // drives one fetch; a miss gets mem_done after dly wait cycles
  // jp_at: wait cycle index for jp_ok (dly = with mem_done, <0 none)
  task automatic fetch(input logic [31:0] pc, input logic [31:0] rd,
                       input int dly, input int jp_at, input bit jp0,
                       output bit missed, output bit resp,
                       output logic [31:0] ins, output logic [31:0] maddr,
                       output int spur);
    missed = 0; resp = 0; ins = '0; maddr = '0; spur = 0;
    pc_cache = pc; pc_flag = 1'b1; jp_ok = jp0;
    tick();
    pc_flag = 1'b0; jp_ok = 1'b0;
    pc_cache = $urandom;
    if (ins_ori_flag) begin
      resp = 1; ins = ins_ori;
      if (mem_req) spur++;
    end else if (mem_req) begin
      missed = 1; maddr = mem_addr;
      for (int i = 0; i < dly; i++) begin
        jp_ok = (i == jp_at);
        tick();
        jp_ok = 1'b0;
        if (ins_ori_flag) spur++;
        if (!mem_req || mem_addr !== maddr) spur++;
      end
      mem_data = rd; mem_done = 1'b1; jp_ok = (jp_at == dly);
      tick();
      mem_done = 1'b0; jp_ok = 1'b0;
      if (ins_ori_flag) begin resp = 1; ins = ins_ori; end
      if (mem_req) spur++;
    end
    tick();
    if (ins_ori_flag || mem_req) spur++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({ins_ori_flag, mem_req} !== 2'b00 || ins_ori !== 32'h0 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: flag=%b req=%b ins=%h addr=%h want all 0",
               ins_ori_flag, mem_req, ins_ori, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    tick();
  endtask

  task automatic test_cold_miss();
    bit m, r; logic [31:0] ins, ma; int sp;
    fetch(32'h0, 32'h93, 4, -1, 0, m, r, ins, ma, sp);
    m_fill(32'h0, 32'h93);
    n_cmp++;
    if (!m || ma !== 32'h0) begin n_bad++;
      $display("FAIL cold_req: req=%b addr=%h want 1 00000000", m, ma); end
    n_cmp++;
    if (!r || ins !== 32'h93 || sp != 0) begin n_bad++;
      $display("FAIL cold_resp: resp=%b ins=%h spur=%0d want 1 00000093 0", r, ins, sp); end
  endtask

  task automatic test_hit();
    bit m, r; logic [31:0] ins, ma; int sp;
    fetch(32'h0, 32'hDEAD, 2, -1, 0, m, r, ins, ma, sp);
    n_cmp++;
    if (m || !r || ins !== 32'h93 || sp != 0) begin n_bad++;
      $display("FAIL hit: miss=%b resp=%b ins=%h spur=%0d want 0 1 00000093 0", m, r, ins, sp); end
  endtask

  task automatic test_conflict();
    bit m, r; logic [31:0] ins, ma; int sp;
    logic [31:0] pcs [3] = '{32'h4, 32'h104, 32'h4};
    logic [31:0] ds  [3] = '{32'hA1, 32'hB2, 32'hC3};
    for (int k = 0; k < 3; k++) begin
      fetch(pcs[k], ds[k], 1, -1, 0, m, r, ins, ma, sp);
      m_fill(pcs[k], ds[k]);
      n_cmp++;
      if (!m || ma !== pcs[k] || !r || ins !== ds[k] || sp != 0) begin n_bad++;
        $display("FAIL conflict%0d: miss=%b addr=%h ins=%h spur=%0d want 1 %h %h 0",
                 k, m, ma, ins, sp, pcs[k], ds[k]); end
    end
  endtask

  task automatic test_squash();
    bit m, r; logic [31:0] ins, ma; int sp;
    fetch(32'h8, 32'h12345678, 3, 1, 0, m, r, ins, ma, sp);
    m_fill(32'h8, 32'h12345678);
    n_cmp++;
    if (!m || r || sp != 0) begin n_bad++;
      $display("FAIL squash: miss=%b resp=%b spur=%0d want 1 0 0", m, r, sp); end
    fetch(32'h8, 32'h0, 1, -1, 0, m, r, ins, ma, sp);
    n_cmp++;
    if (m || !r || ins !== 32'h12345678) begin n_bad++;
      $display("FAIL squash_fill: miss=%b resp=%b ins=%h want 0 1 12345678", m, r, ins); end
  endtask

  task automatic test_coincident();
    bit m, r; logic [31:0] ins, ma; int sp;
    fetch(32'h20, 32'h55, 1, -1, 1, m, r, ins, ma, sp);
    n_cmp++;
    if (m || r || sp != 0) begin n_bad++;
      $display("FAIL coincident: miss=%b resp=%b spur=%0d want 0 0 0", m, r, sp); end
    fetch(32'h0, 32'h55, 1, -1, 1, m, r, ins, ma, sp);
    n_cmp++;
    if (m || r || sp != 0) begin n_bad++;
      $display("FAIL coincident_hit: miss=%b resp=%b spur=%0d want 0 0 0", m, r, sp); end
  endtask

  task automatic test_reset_mid_miss();
    bit m, r; logic [31:0] ins, ma; int sp;
    pc_cache = 32'h40; pc_flag = 1'b1;
    tick();
    pc_flag = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || ins_ori_flag !== 1'b0 || ins_ori !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid: req=%b addr=%h flag=%b ins=%h want 0 0 0 0",
               mem_req, mem_addr, ins_ori_flag, ins_ori); end
    tick();
    rst_n = 1'b1;
    m_clear();
    mem_data = 32'hBAD; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    n_cmp++;
    if (ins_ori_flag !== 1'b0 || mem_req !== 1'b0) begin n_bad++;
      $display("FAIL late_done: flag=%b req=%b want 0 0", ins_ori_flag, mem_req); end
    fetch(32'h0, 32'h77, 1, -1, 0, m, r, ins, ma, sp);
    m_fill(32'h0, 32'h77);
    n_cmp++;
    if (!m || !r || ins !== 32'h77) begin n_bad++;
      $display("FAIL post_reset: miss=%b resp=%b ins=%h want 1 1 00000077", m, r, ins); end
  endtask

  task automatic test_stall();
    int hi = 0;
    pc_cache = 32'h0; pc_flag = 1'b1;
    tick();
    pc_flag = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ins_ori_flag === 1'b1 && ins_ori === 32'h77) hi++;
      tick();
    end
    rdy = 1'b1;
    if (ins_ori_flag === 1'b1) hi++;
    tick();
    n_cmp++;
    if (hi != 4 || ins_ori_flag !== 1'b0) begin n_bad++;
      $display("FAIL stall: high_cycles=%0d flag_after=%b want 4 0", hi, ins_ori_flag); end
  endtask

  task automatic test_random();
    bit m, r; logic [31:0] ins, ma; int sp;
    logic [31:0] pc, rd;
    int dly, jp_at;
    bit jp0, eh, er;
    logic [31:0] ei;
    int bad = 0;
    for (int it = 0; it < 60; it++) begin
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) pc = 32'hFFFFFFFC;
      if ($urandom_range(0, 9) == 0) pc = 32'h000000FC;
      rd = $urandom;
      dly = $urandom_range(0, 4);
      jp_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dly) : -1;
      jp0 = ($urandom_range(0, 9) == 0);
      eh = m_hit(pc);
      ei = eh ? m_data[line_of(pc)] : rd;
      er = !jp0 && (eh || jp_at < 0);
      fetch(pc, rd, dly, jp_at, jp0, m, r, ins, ma, sp);
      if (!jp0 && !eh) m_fill(pc, rd);
      n_cmp++;
      if (m !== (!jp0 && !eh) || r !== er || sp != 0
          || (m && ma !== {pc[31:2], 2'b00}) || (r && ins !== ei)) begin
        n_bad++;
        if (bad++ < 10)
          $display("FAIL random%0d pc=%h: miss=%b resp=%b ins=%h addr=%h spur=%0d want miss=%b resp=%b ins=%h",
                   it, pc, m, r, ins, ma, sp, !jp0 && !eh, er, ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_squash();
    test_coincident();
    test_reset_mid_miss();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
